pf_mem_arbiter: RTL and testbench

Memory-side responder for the prefetcher's `pf_read`/`pf_resp` port and the cache's demand-miss port. Sits between these two requesters and the single 256-bit physical-memory (cacheline adapter) port. Arbitrates one cacheline transaction at a time, gives demand traffic priority, and forwards memory data and completion back to whichever requester was granted. A starvation counter prevents an outstanding prefetch from waiting indefinitely.

---
 rtl/pf_mem_arbiter.sv | 111 +++++++++++
 tb/tb_pf_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pf_mem_arbiter
// Purpose  : Arbitrates demand-miss and prefetch cacheline requests onto a
//            single 256-bit physical-memory port, with prefetch anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
module pf_mem_arbiter #(
   parameter int PF_STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   // demand (cache) port
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [31:0]  mem_address,
   input  logic [255:0] mem_wdata,
   output logic [255:0] mem_rdata,
   output logic         mem_resp,
   // prefetcher port
   input  logic         pf_read,
   input  logic [31:0]  pf_address,
   output logic [255:0] pf_rdata,
   output logic         pf_resp,
   // physical memory port
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp
);

   localparam int c_CNT_W = $clog2(PF_STARVE_LIMIT + 1);
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(PF_STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEMAND   = 2'd1,
      S_PREFETCH = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_starve_cnt;

   logic w_dem_req;
   logic w_pf_wins;

   assign w_dem_req = mem_read | mem_write;
   assign w_pf_wins = pf_read && (r_starve_cnt == c_LIMIT);

   assign mem_rdata = pmem_rdata;
   assign pf_rdata  = pmem_rdata;
   assign mem_resp  = pmem_resp && (r_state == S_DEMAND);
   assign pf_resp   = pmem_resp && (r_state == S_PREFETCH);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_starve_cnt <= '0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_dem_req && !w_pf_wins) begin
                  r_state      <= S_DEMAND;
                  pmem_address <= mem_address;
                  pmem_read    <= mem_read;
                  pmem_write   <= mem_write;
                  if (mem_write) begin
                     pmem_wdata <= mem_wdata;
                  end
                  // Counter is below the limit here whenever pf_read is high, so no wrap.
                  if (pf_read) begin
                     r_starve_cnt <= r_starve_cnt + 1'b1;
                  end else begin
                     r_starve_cnt <= '0;
                  end
               end else if (pf_read) begin
                  r_state      <= S_PREFETCH;
                  pmem_address <= pf_address;
                  pmem_read    <= 1'b1;
                  pmem_write   <= 1'b0;
                  r_starve_cnt <= '0;
               end else begin
                  r_starve_cnt <= '0;
               end
            end
            S_DEMAND, S_PREFETCH: begin
               if (pmem_resp) begin
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pf_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pf_mem_arbiter
// Purpose  : Scoreboard bench for pf_mem_arbiter with a fixed-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pf_mem_arbiter;

   localparam int LAT   = 5;
   localparam int LIMIT = 4;
   localparam int TMO   = 300;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read, mem_write, pf_read;
   logic [31:0]  mem_address, pf_address;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata, pf_rdata;
   logic         mem_resp, pf_resp;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   typedef struct {
      logic [31:0]  addr;
      logic         wr;
      logic [255:0] wdata;
      logic         pf;
      logic [255:0] rdata;
   } txn_t;

   txn_t sb[$];
   int   n_checks = 0;
   int   n_err    = 0;
   bit   mem_auto = 1'b0;
   int   cyc      = 0;
   int   mem_resp_cnt = 0;
   int   pf_resp_cnt  = 0;

   pf_mem_arbiter #(.PF_STARVE_LIMIT(LIMIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp),
      .pf_read      (pf_read),
      .pf_address   (pf_address),
      .pf_rdata     (pf_rdata),
      .pf_resp      (pf_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (mem_resp === 1'b1) mem_resp_cnt++;
      if (pf_resp === 1'b1)  pf_resp_cnt++;
   end

   // Memory model: each new strobe pops the next expected grant and checks it.
   initial begin : mem_model
      txn_t g;
      forever begin
         @(posedge clk); #1;
         if (mem_auto && (pmem_read || pmem_write)) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL grant_unexpected: got addr=%h rd=%b wr=%b, expected no grant",
                        pmem_address, pmem_read, pmem_write);
               g.addr = pmem_address; g.wr = pmem_write; g.wdata = pmem_wdata;
               g.pf = 1'b0; g.rdata = '0;
            end else begin
               g = sb.pop_front();
               if (pmem_address !== g.addr || pmem_write !== g.wr || pmem_read !== !g.wr ||
                   (g.wr && pmem_wdata !== g.wdata)) begin
                  n_err++;
                  $display("FAIL grant: got addr=%h rd=%b wr=%b, expected addr=%h rd=%b wr=%b",
                           pmem_address, pmem_read, pmem_write, g.addr, !g.wr, g.wr);
               end
            end
            for (int i = 1; i < LAT; i++) begin
               @(posedge clk); #1;
               n_checks++;
               if (pmem_read !== !g.wr || pmem_write !== g.wr || pmem_address !== g.addr ||
                   (g.wr && pmem_wdata !== g.wdata)) begin
                  n_err++;
                  $display("FAIL strobe_hold: got addr=%h rd=%b wr=%b, expected addr=%h rd=%b wr=%b",
                           pmem_address, pmem_read, pmem_write, g.addr, !g.wr, g.wr);
               end
               if (i == LAT - 1) begin
                  pmem_rdata = g.rdata;
                  pmem_resp  = 1'b1;
               end
            end
            @(negedge clk);
            n_checks++;
            if (mem_resp !== !g.pf || pf_resp !== g.pf) begin
               n_err++;
               $display("FAIL resp_route: got mem_resp=%b pf_resp=%b, expected %b %b",
                        mem_resp, pf_resp, !g.pf, g.pf);
            end
            n_checks++;
            if (mem_rdata !== g.rdata || pf_rdata !== g.rdata) begin
               n_err++;
               $display("FAIL resp_data: got %h, expected %h", g.pf ? pf_rdata : mem_rdata, g.rdata);
            end
            @(posedge clk); #1;
            pmem_resp  = 1'b0;
            pmem_rdata = ~g.rdata;
            n_checks++;
            if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
               n_err++;
               $display("FAIL done_strobe: got rd=%b wr=%b, expected 0 0", pmem_read, pmem_write);
            end
         end
      end
   end

   task automatic dem_req(input logic [31:0] a, input logic wr, input logic [255:0] wd,
                          input bit chk_lat, output int t_resp);
      int n;
      bit got;
      mem_address = a; mem_wdata = wd; mem_read = !wr; mem_write = wr;
      got = 1'b0; n = 0; t_resp = -1;
      while (!got && n < TMO) begin
         @(negedge clk); n++;
         if (chk_lat && n == 1) begin
            n_checks++;
            if (pmem_read !== !wr || pmem_write !== wr || pmem_address !== a) begin
               n_err++;
               $display("FAIL grant_latency: got rd=%b wr=%b addr=%h, expected %b %b %h",
                        pmem_read, pmem_write, pmem_address, !wr, wr, a);
            end
         end
         if (mem_resp === 1'b1) begin got = 1'b1; t_resp = cyc; end
      end
      mem_read = 1'b0; mem_write = 1'b0;
      if (!got) begin
         n_checks++; n_err++;
         $display("FAIL demand_timeout: got no mem_resp for %h, expected one within %0d cycles", a, TMO);
      end
   endtask

   task automatic pf_req(input logic [31:0] a, output int t_resp);
      int n;
      bit got;
      pf_address = a; pf_read = 1'b1;
      got = 1'b0; n = 0; t_resp = -1;
      while (!got && n < TMO) begin
         @(negedge clk); n++;
         if (pf_resp === 1'b1) begin got = 1'b1; t_resp = cyc; end
      end
      pf_read = 1'b0;
      if (!got) begin
         n_checks++; n_err++;
         $display("FAIL prefetch_timeout: got no pf_resp for %h, expected one within %0d cycles", a, TMO);
      end
   endtask

   function automatic txn_t mk(input logic [31:0] a, input logic wr, input logic [255:0] wd,
                               input logic pf);
      txn_t t;
      t.addr = a; t.wr = wr; t.wdata = wd; t.pf = pf; t.rdata = {8{a ^ 32'h5A5A_0000}};
      return t;
   endfunction

   task automatic test_reset;
      logic [255:0] pat;
      pat = {8{32'hDEAD_BEEF}};
      rst = 1'b1; pmem_rdata = pat; pmem_resp = 1'b1;
      mem_read = 1'b1; pf_read = 1'b1; mem_address = 32'h7000; pf_address = 32'h7020;
      repeat (3) @(negedge clk);
      n_checks++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== 32'h0 || pmem_wdata !== '0) begin
         n_err++;
         $display("FAIL reset_pmem: got rd=%b wr=%b addr=%h, expected 0 0 0", pmem_read, pmem_write, pmem_address);
      end
      n_checks++;
      if (mem_resp !== 1'b0 || pf_resp !== 1'b0) begin
         n_err++;
         $display("FAIL reset_resp: got mem_resp=%b pf_resp=%b, expected 0 0", mem_resp, pf_resp);
      end
      n_checks++;
      if (mem_rdata !== pat || pf_rdata !== pat) begin
         n_err++;
         $display("FAIL reset_rdata: got %h, expected %h", mem_rdata, pat);
      end
      n_checks++;
      if (dut.r_starve_cnt !== 3'd0 || dut.r_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_state: got state=%0d cnt=%0d, expected 0 0", dut.r_state, dut.r_starve_cnt);
      end
      mem_read = 1'b0; pf_read = 1'b0; pmem_resp = 1'b0; rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: got rd=%b mem_resp=%b, expected 0 0", pmem_read, mem_resp);
      end
      mem_auto = 1'b1;
   endtask

   task automatic test_demand_read;
      txn_t t;
      int tr, m0, p0;
      m0 = mem_resp_cnt; p0 = pf_resp_cnt;
      t = mk(32'h1000, 1'b0, '0, 1'b0);
      t.rdata = {32{8'hA5}};
      sb.push_back(t);
      dem_req(32'h1000, 1'b0, '0, 1'b1, tr);
      repeat (2) @(negedge clk);
      n_checks++;
      if (mem_resp_cnt - m0 != 1 || pf_resp_cnt - p0 != 0) begin
         n_err++;
         $display("FAIL demand_pulses: got mem=%0d pf=%0d, expected 1 0", mem_resp_cnt - m0, pf_resp_cnt - p0);
      end
   endtask

   task automatic test_prefetch;
      int tp, m0, p0;
      m0 = mem_resp_cnt; p0 = pf_resp_cnt;
      sb.push_back(mk(32'h1020, 1'b0, '0, 1'b1));
      pf_req(32'h1020, tp);
      repeat (2) @(negedge clk);
      n_checks++;
      if (mem_resp_cnt - m0 != 0 || pf_resp_cnt - p0 != 1) begin
         n_err++;
         $display("FAIL prefetch_pulses: got mem=%0d pf=%0d, expected 0 1", mem_resp_cnt - m0, pf_resp_cnt - p0);
      end
   endtask

   task automatic test_writeback;
      int tr, m0;
      logic [255:0] wd;
      wd = {16{16'h1234}};
      m0 = mem_resp_cnt;
      sb.push_back(mk(32'h3000, 1'b1, wd, 1'b0));
      dem_req(32'h3000, 1'b1, wd, 1'b1, tr);
      repeat (2) @(negedge clk);
      n_checks++;
      if (mem_resp_cnt - m0 != 1) begin
         n_err++;
         $display("FAIL write_pulses: got mem=%0d, expected 1", mem_resp_cnt - m0);
      end
   endtask

   task automatic test_simultaneous;
      int tr, tp;
      sb.push_back(mk(32'h2000, 1'b0, '0, 1'b0));
      sb.push_back(mk(32'h2020, 1'b0, '0, 1'b1));
      fork
         pf_req(32'h2020, tp);
         begin
            dem_req(32'h2000, 1'b0, '0, 1'b0, tr);
            n_checks++;
            if (dut.r_starve_cnt !== 3'd1) begin
               n_err++;
               $display("FAIL simul_cnt: got %0d, expected 1", dut.r_starve_cnt);
            end
         end
      join
      n_checks++;
      if (tr < 0 || tp < 0 || tp - tr < LAT + 2) begin
         n_err++;
         $display("FAIL simul_order: got mem@%0d pf@%0d, expected pf at least %0d cycles after mem",
                  tr, tp, LAT + 2);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_starvation;
      int tp;
      for (int i = 0; i < 4; i++) sb.push_back(mk(32'h4000 + 32'(i * 32), 1'b0, '0, 1'b0));
      sb.push_back(mk(32'h5000, 1'b0, '0, 1'b1));
      for (int i = 4; i < 6; i++) sb.push_back(mk(32'h4000 + 32'(i * 32), 1'b0, '0, 1'b0));
      fork
         begin
            pf_req(32'h5000, tp);
            n_checks++;
            if (dut.r_starve_cnt !== 3'd0) begin
               n_err++;
               $display("FAIL starve_clear: got %0d, expected 0", dut.r_starve_cnt);
            end
         end
         begin
            for (int i = 0; i < 6; i++) begin
               int tr;
               logic [2:0] e;
               e = (i < 4) ? 3'(i + 1) : 3'd0;
               dem_req(32'h4000 + 32'(i * 32), 1'b0, '0, 1'b0, tr);
               n_checks++;
               if (dut.r_starve_cnt !== e) begin
                  n_err++;
                  $display("FAIL starve_cnt[%0d]: got %0d, expected %0d", i, dut.r_starve_cnt, e);
               end
            end
         end
      join
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_prefetch;
      int n, p0;
      mem_auto = 1'b0;
      p0 = pf_resp_cnt;
      pf_address = 32'h6000; pf_read = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (pmem_read !== 1'b1 && n < TMO);
      n_checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h6000) begin
         n_err++;
         $display("FAIL rst_grant: got rd=%b addr=%h, expected 1 00006000", pmem_read, pmem_address);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; pf_read = 1'b0;
      n_checks++;
      if (pmem_read !== 1'b0 || pmem_address !== 32'h0 || dut.r_state !== 2'd0) begin
         n_err++;
         $display("FAIL rst_abort: got rd=%b addr=%h state=%0d, expected 0 0 0",
                  pmem_read, pmem_address, dut.r_state);
      end
      pmem_rdata = {8{32'hCAFE_F00D}}; pmem_resp = 1'b1;
      #1;
      n_checks++;
      if (pf_resp !== 1'b0 || mem_resp !== 1'b0) begin
         n_err++;
         $display("FAIL rst_late_resp: got pf_resp=%b mem_resp=%b, expected 0 0", pf_resp, mem_resp);
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pf_resp_cnt != p0 || dut.r_state !== 2'd0 || pmem_read !== 1'b0) begin
         n_err++;
         $display("FAIL rst_final: got pf pulses=%0d state=%0d rd=%b, expected 0 0 0",
                  pf_resp_cnt - p0, dut.r_state, pmem_read);
      end
      mem_auto = 1'b1;
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pf_read = 1'b0;
      mem_address = '0; pf_address = '0; mem_wdata = '0;
      pmem_rdata = '0; pmem_resp = 1'b0;
      @(negedge clk);
      test_reset();
      test_demand_read();
      test_prefetch();
      test_writeback();
      test_simultaneous();
      test_starvation();
      test_reset_mid_prefetch();
      n_checks++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: got %0d pending grants, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
